sar_converter: RTL



---
 rtl/sar_converter.sv | 97 +++++++++
 1 files changed

// File: rtl/sar_converter.sv
// Successive-approximation converter controller: runs 8 bit trials against an
// external DAC/comparator and serves a 4-phase soc/eoc handshake to the consumer.
//
// state    | meaning
// S_IDLE   | eoc=1, x valid, waiting for soc
// S_SETTLE | DAC settling for the current trial code
// S_DECIDE | sample cmp, keep/clear current bit, set next trial bit
// S_HOLD   | final code ready, waiting for soc to drop before raising eoc
module sar_converter #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clock,
    input  logic       reset_,
    input  logic       soc,
    output logic       eoc,
    output logic [7:0] x,
    output logic [7:0] dac,
    input  logic       cmp
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_DECIDE,
        S_HOLD
    } state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t     state_q;
    logic [2:0] bit_q;
    logic [3:0] cnt_q;
    logic [7:0] dac_q;
    logic [7:0] x_q;
    logic       eoc_q;

    logic [7:0] bit_mask;
    logic [7:0] dac_kept;

    assign bit_mask = 8'h01 << bit_q;
    // A low comparator means the trial code overshot the input: drop the bit.
    assign dac_kept = cmp ? dac_q : (dac_q & ~bit_mask);

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= S_IDLE;
            bit_q   <= 3'd0;
            cnt_q   <= 4'd0;
            dac_q   <= 8'h00;
            x_q     <= 8'h00;
            eoc_q   <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (soc) begin
                        eoc_q   <= 1'b0;
                        dac_q   <= 8'h80;
                        bit_q   <= 3'd7;
                        cnt_q   <= SETTLE_C;
                        state_q <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == 4'd1) begin
                        state_q <= S_DECIDE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_DECIDE: begin
                    if (bit_q == 3'd0) begin
                        dac_q   <= dac_kept;
                        state_q <= S_HOLD;
                    end else begin
                        dac_q   <= dac_kept | (bit_mask >> 1);
                        bit_q   <= bit_q - 3'd1;
                        cnt_q   <= SETTLE_C;
                        state_q <= S_SETTLE;
                    end
                end
                S_HOLD: begin
                    if (!soc) begin
                        x_q     <= dac_q;
                        eoc_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign eoc = eoc_q;
    assign x   = x_q;
    assign dac = dac_q;

endmodule
